// File: rtl/frame_stream_packer_pkg.sv
// Shared types and queue-entry encodings for the capture pixel queue.
// Latency: n/a (declarations only).
// Backpressure: n/a. The frame uploader imports the marker constants from here.
package FrameStreamTypes;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VSYNC = 2'd1,
        ST_WAIT_ROW   = 2'd2,
        ST_IN_ROW     = 2'd3
    } state_t;

    // Bit 16 set marks an in-band framing entry; clear marks a pixel.
    localparam logic [16:0] FRAME_START_MARK = 17'h10000;
    localparam logic [16:0] ROW_START_MARK   = 17'h10001;

    localparam int          COL_W   = 11;
    localparam logic [10:0] COL_MAX = 11'h7FF;

    // The first camera byte of a pair is the high half of the RGB565 word.
    function automatic logic [16:0] pixel_word(input logic [7:0] hi, input logic [7:0] lo);
        return {1'b0, hi, lo};
    endfunction

endpackage

// File: rtl/frame_stream_packer_if.sv
// Camera-side inputs, queue write port and status outputs of the packer.
// Latency: n/a (wiring only).
// Backpressure: queue_full from the queue; writes are dropped, never stalled.
// Ports: start/vsync/href/byte_valid/pixel_byte/queue_full flow into the packer;
//        queue_wr_en/queue_data/capturing/frame_done/overflow/geometry_error flow out.
interface frame_stream_packer_if;
    logic        start;
    logic        vsync;
    logic        href;
    logic        byte_valid;
    logic [7:0]  pixel_byte;
    logic        queue_full;
    logic        queue_wr_en;
    logic [16:0] queue_data;
    logic        capturing;
    logic        frame_done;
    logic        overflow;
    logic        geometry_error;

    // master: camera controller / camera / queue side driving the packer
    modport master (
        output start, vsync, href, byte_valid, pixel_byte, queue_full,
        input  queue_wr_en, queue_data, capturing, frame_done, overflow, geometry_error
    );

    // slave: the packer itself
    modport slave (
        input  start, vsync, href, byte_valid, pixel_byte, queue_full,
        output queue_wr_en, queue_data, capturing, frame_done, overflow, geometry_error
    );
endinterface

// File: rtl/frame_stream_packer_signal_edge_detect.sv
// Rise/fall detector against a one-cycle registered copy of the input.
// Latency: edges are flagged in the same cycle the new level is sampled.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), sig in; rise, fall out.
module signal_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);
    logic sig_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_d <= 1'b0;
        end else begin
            sig_d <= sig;
        end
    end

    assign rise = sig & ~sig_d;
    assign fall = ~sig & sig_d;
endmodule

// File: rtl/frame_stream_packer.sv
// Packs OV7670 byte pairs into RGB565 queue entries with in-band frame/row markers.
// Latency: one cycle from the sampled vsync fall, href rise or second byte to queue_wr_en.
// Backpressure: a write meeting queue_full is dropped and flags sticky overflow; no stall.
// Ports: clk, reset (sync, active-high), bus (frame_stream_packer_if.slave).
module frame_stream_packer
    import FrameStreamTypes::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    frame_stream_packer_if.slave  bus
);
    localparam int                ROW_W     = $clog2(FRAME_HEIGHT + 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(FRAME_HEIGHT - 1);
    localparam logic [COL_W-1:0]  WIDTH_CNT = COL_W'(FRAME_WIDTH);

    state_t             state;
    logic [ROW_W-1:0]   row_cnt;
    logic [COL_W-1:0]   col_cnt;
    logic               phase;      // 1: high byte latched, waiting for low byte
    logic [7:0]         hi_byte;

    logic vsync_rise, vsync_fall, href_rise, href_fall;

    signal_edge_detect u_vsync_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.vsync),
        .rise  (vsync_rise),
        .fall  (vsync_fall)
    );

    signal_edge_detect u_href_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (bus.href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    // Write request for this cycle. Only one source can be active per state,
    // so markers and pixels never compete for the single write slot.
    logic        emit_req;
    logic [16:0] emit_val;

    always_comb begin
        emit_req = 1'b0;
        emit_val = '0;
        case (state)
            ST_WAIT_VSYNC: begin
                if (vsync_fall) begin
                    emit_req = 1'b1;
                    emit_val = FRAME_START_MARK;
                end
            end
            ST_WAIT_ROW: begin
                if (href_rise) begin
                    emit_req = 1'b1;
                    emit_val = ROW_START_MARK;
                end
            end
            ST_IN_ROW: begin
                // A strobe coinciding with the href fall is outside the row.
                if (!href_fall && bus.byte_valid && phase) begin
                    emit_req = 1'b1;
                    emit_val = pixel_word(hi_byte, bus.pixel_byte);
                end
            end
            default: begin
                emit_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            row_cnt            <= '0;
            col_cnt            <= '0;
            phase              <= 1'b0;
            hi_byte            <= '0;
            bus.queue_wr_en    <= 1'b0;
            bus.queue_data     <= '0;
            bus.capturing      <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.overflow       <= 1'b0;
            bus.geometry_error <= 1'b0;
        end else begin
            bus.frame_done  <= 1'b0;
            bus.queue_wr_en <= emit_req && !bus.queue_full;
            if (emit_req && !bus.queue_full) begin
                bus.queue_data <= emit_val;
            end
            if (emit_req && bus.queue_full) begin
                bus.overflow <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state              <= ST_WAIT_VSYNC;
                        bus.capturing      <= 1'b1;
                        bus.overflow       <= 1'b0;
                        bus.geometry_error <= 1'b0;
                        row_cnt            <= '0;
                        col_cnt            <= '0;
                        phase              <= 1'b0;
                    end
                end

                ST_WAIT_VSYNC: begin
                    if (vsync_fall) begin
                        state <= ST_WAIT_ROW;
                    end
                end

                ST_WAIT_ROW: begin
                    if (href_rise) begin
                        state   <= ST_IN_ROW;
                        col_cnt <= '0;
                        if (bus.byte_valid) begin
                            hi_byte <= bus.pixel_byte;
                            phase   <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                        end
                    end else if (vsync_rise) begin
                        // Frame ended before all rows arrived.
                        state              <= ST_IDLE;
                        bus.capturing      <= 1'b0;
                        bus.frame_done     <= 1'b1;
                        bus.geometry_error <= 1'b1;
                    end
                end

                ST_IN_ROW: begin
                    if (href_fall) begin
                        phase <= 1'b0;   // an orphan high byte is discarded
                        if (phase || (col_cnt != WIDTH_CNT)) begin
                            bus.geometry_error <= 1'b1;
                        end
                        if (row_cnt == LAST_ROW) begin
                            state          <= ST_IDLE;
                            bus.capturing  <= 1'b0;
                            bus.frame_done <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                            state   <= ST_WAIT_ROW;
                        end
                    end else if (bus.byte_valid) begin
                        if (!phase) begin
                            hi_byte <= bus.pixel_byte;
                            phase   <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            // Saturate so a runaway row still reads as a width error.
                            if (col_cnt != COL_MAX) begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_stream_packer.sv
// Directed bench for frame_stream_packer at FRAME_WIDTH=4, FRAME_HEIGHT=2.
// Latency: n/a.
// Backpressure: queue_full driven from the stimulus.
module tb_frame_stream_packer;
    import FrameStreamTypes::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_stream_packer_if bus ();

    frame_stream_packer #(
        .FRAME_WIDTH  (4),
        .FRAME_HEIGHT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [16:0] wr_log[$];
    logic [16:0] exp_q[$];

    // Sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus.queue_wr_en) wr_log.push_back(bus.queue_data);
        if (bus.frame_done)  done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] byte_at(input int k);
        return 8'((k + 1) * 17);   // 0x11, 0x22, ... wrapping
    endfunction

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.vsync      = 1'b1;
        bus.href       = 1'b0;
        bus.byte_valid = 1'b0;
        bus.pixel_byte = 8'h00;
        bus.queue_full = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        wr_log.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic arm();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
    endtask

    task automatic frame_begin();
        bus.vsync = 1'b1;
        tick();
        tick();
        bus.vsync = 1'b0;
        tick();
        tick();
    endtask

    // nbytes strobes every other cycle; queue_full held while byte full_at is sampled.
    task automatic send_row(input int nbytes, input int base, input int full_at);
        bus.href = 1'b1;
        tick();
        for (int k = 0; k < nbytes; k++) begin
            bus.byte_valid = 1'b1;
            bus.pixel_byte = byte_at(base + k);
            bus.queue_full = (k == full_at);
            tick();
            bus.byte_valid = 1'b0;
            bus.queue_full = 1'b0;
            tick();
        end
        bus.href = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_count"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {15'd0, wr_log[i]}, {15'd0, exp_q[i]});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_en"},     bus.queue_wr_en,    0);
        chk({tag, "_data"},      bus.queue_data,     0);
        chk({tag, "_capturing"}, bus.capturing,      0);
        chk({tag, "_done"},      bus.frame_done,     0);
        chk({tag, "_overflow"},  bus.overflow,       0);
        chk({tag, "_geom"},      bus.geometry_error, 0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // ---------------- reset state and nominal frame ----------------
        do_reset();
        chk_outputs_zero("rst");

        arm();
        chk("nom_capturing", bus.capturing, 1);
        bus.vsync = 1'b0;
        chk("nom_pre_edge_wr", bus.queue_wr_en, 0);
        tick();
        chk("nom_vsync_lat_wr", bus.queue_wr_en, 1);
        chk("nom_vsync_lat_data", bus.queue_data, 17'h10000);
        tick();
        chk("nom_wr_single", bus.queue_wr_en, 0);
        send_row(8, 0, -1);
        send_row(8, 8, -1);
        bus.vsync = 1'b1;
        tick();
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h03344, 17'h05566, 17'h07788,
                  17'h10001, 17'h099AA, 17'h0BBCC, 17'h0DDEE, 17'h0FF10};
        chk_log("nom");
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_overflow", bus.overflow, 0);
        chk("nom_geom", bus.geometry_error, 0);
        chk("nom_capturing_end", bus.capturing, 0);

        // ---------------- queue full on second pixel of row 0 ----------------
        do_reset();
        arm();
        frame_begin();
        send_row(8, 0, 3);
        send_row(8, 8, -1);
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h05566, 17'h07788,
                  17'h10001, 17'h099AA, 17'h0BBCC, 17'h0DDEE, 17'h0FF10};
        chk_log("full");
        chk("full_overflow", bus.overflow, 1);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_geom", bus.geometry_error, 0);

        // ---------------- odd byte count in row 0 ----------------
        do_reset();
        arm();
        frame_begin();
        send_row(7, 0, -1);
        send_row(8, 8, -1);
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h03344, 17'h05566,
                  17'h10001, 17'h099AA, 17'h0BBCC, 17'h0DDEE, 17'h0FF10};
        chk_log("odd");
        chk("odd_geom", bus.geometry_error, 1);
        chk("odd_done_cnt", done_cnt, 1);
        chk("odd_overflow", bus.overflow, 0);

        // ---------------- short frame: vsync rises after one row ----------------
        do_reset();
        arm();
        frame_begin();
        send_row(8, 0, -1);
        bus.vsync = 1'b1;
        tick();
        chk("short_done_pulse", bus.frame_done, 1);
        tick();
        chk("short_done_low", bus.frame_done, 0);
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h03344, 17'h05566, 17'h07788};
        chk_log("short");
        chk("short_geom", bus.geometry_error, 1);
        chk("short_capturing", bus.capturing, 0);
        chk("short_done_cnt", done_cnt, 1);

        // ---------------- arming ----------------
        do_reset();
        frame_begin();              // vsync fall while idle
        send_row(8, 0, -1);         // href activity while idle
        chk("arm_idle_writes", wr_log.size(), 0);
        bus.vsync = 1'b1;
        tick();
        arm();
        send_row(4, 0, -1);         // href while waiting for vsync
        chk("arm_wait_vsync_writes", wr_log.size(), 0);
        frame_begin();
        bus.start = 1'b1;           // start during capture
        tick();
        bus.start = 1'b0;
        tick();
        send_row(8, 0, -1);
        send_row(8, 8, -1);
        chk("arm_capturing_end", bus.capturing, 0);
        frame_begin();              // must not start a new frame
        send_row(8, 0, -1);
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h03344, 17'h05566, 17'h07788,
                  17'h10001, 17'h099AA, 17'h0BBCC, 17'h0DDEE, 17'h0FF10};
        chk_log("arm");
        chk("arm_done_cnt", done_cnt, 1);

        // ---------------- reset mid-row ----------------
        do_reset();
        arm();
        frame_begin();
        bus.href = 1'b1;
        tick();
        bus.byte_valid = 1'b1;
        bus.pixel_byte = 8'h11;
        tick();
        bus.byte_valid = 1'b0;
        tick();
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        bus.pixel_byte = 8'h22;
        tick();
        chk_outputs_zero("mid_rst");
        reset = 1'b0;
        bus.byte_valid = 1'b0;
        bus.href = 1'b0;
        wr_log.delete();
        done_cnt = 0;
        tick();
        chk("mid_rst_no_write", wr_log.size(), 0);
        arm();
        frame_begin();
        send_row(8, 0, -1);
        send_row(8, 8, -1);
        exp_q = '{17'h10000, 17'h10001, 17'h01122, 17'h03344, 17'h05566, 17'h07788,
                  17'h10001, 17'h099AA, 17'h0BBCC, 17'h0DDEE, 17'h0FF10};
        chk_log("post_rst");
        chk("post_rst_geom", bus.geometry_error, 0);
        chk("post_rst_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_stream_packer.md
# frame_stream_packer

- Capture-side formatter between the OV7670 byte interface (already synchronised into the system clock) and the pixel queue drained by the frame uploader.
- Assembles camera byte pairs into RGB565 words and writes one 17-bit queue entry per pixel. Framing is in-band: a frame-start marker before the first row and a row-start marker before each row.
- Checks frame geometry, drops writes when the queue is full, and reports completion and error status to the camera controller.

## Interface
Parameters:
- FRAME_WIDTH, 640, pixels per row (byte pairs per href pulse)
- FRAME_HEIGHT, 480, rows per frame

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms capture of exactly one frame
- vsync  in  1  camera VSYNC, synchronised; high between frames
- href  in  1  camera HREF, synchronised; high while a row is transferred
- byte_valid  in  1  one-cycle strobe, pixel_byte is valid
- pixel_byte  in  8  camera data byte
- queue_full  in  1  pixel queue cannot accept a write
- queue_wr_en  out  1  queue write strobe
- queue_data  out  17  queue entry; bit16=1 marker, bit16=0 pixel {1'b0, rgb565}
- capturing  out  1  high from arm until frame end
- frame_done  out  1  one-cycle pulse at frame end
- overflow  out  1  sticky: a write was dropped because queue_full
- geometry_error  out  1  sticky: odd byte count in a row, wrong pixel count in a row, or short frame

## Operation
- Markers: FRAME_START = 17'h10000, ROW_START = 17'h10001. Pixel = {1'b0, first_byte, second_byte}.
- Edge detect uses registered vsync_d and href_d.
  - vsync fall = !vsync && vsync_d
  - href rise = href && !href_d
  - href fall = !href && href_d
- States:
  - IDLE: start -> WAIT_VSYNC. Clears overflow, geometry_error, row counter and column counter.
  - WAIT_VSYNC: vsync fall -> emit FRAME_START, go to WAIT_ROW. href activity in this state is ignored.
  - WAIT_ROW:
    - href rise -> emit ROW_START, clear column counter and byte phase, go to IN_ROW. A byte_valid in the same cycle is latched as the high byte.
    - vsync rise before FRAME_HEIGHT rows -> set geometry_error, pulse frame_done, go to IDLE.
  - IN_ROW:
    - byte_valid with phase 0: latch high byte.
    - byte_valid with phase 1: emit pixel, increment column counter. Column counter is 11 bits and saturates at 2047.
    - href fall, phase 1 pending: discard the byte, set geometry_error.
    - href fall, column counter != FRAME_WIDTH: set geometry_error.
    - href fall, row counter + 1 == FRAME_HEIGHT: pulse frame_done, go to IDLE.
    - href fall, otherwise: row counter += 1, go to WAIT_ROW.
- "Emit" means a write is required this cycle:
  - queue_full low: queue_wr_en = 1 and queue_data = the value.
  - queue_full high: the write is dropped, overflow is set, and the FSM continues unchanged. Nothing is retried or buffered.
- start is ignored outside IDLE.
- capturing = (state != IDLE).

## Timing
- All outputs are registered. Reset values: queue_wr_en 0, queue_data 0, capturing 0, frame_done 0, overflow 0, geometry_error 0; state IDLE.
- Latency from input event to write: vsync fall, href rise, or second byte_valid sampled at edge N gives queue_wr_en high for the single cycle after edge N.
- queue_full is sampled in the same cycle the write decision is made.
- At most one write per cycle. Markers and pixels cannot collide, because the row marker coincides at most with a high-byte latch.
- frame_done is high for exactly one cycle, in the cycle after the terminating href fall or vsync rise.
- byte_valid faster than every other cycle is legal: each strobe toggles the byte phase.
- Reset mid-frame: returns to IDLE within one cycle, the latched partial byte is discarded, and no write is issued in the cycle reset is high.

## Structure
- Package FrameStreamTypes holds:
  - the state enum
  - FRAME_START_MARK and ROW_START_MARK constants
- The frame uploader must import the same marker constants rather than using literals.
- One sub-module: signal_edge_detect, a registered rise/fall detector instantiated for vsync and href.
- Counters and packing live in the top module.

## Test plan
All scenarios use FRAME_WIDTH=4, FRAME_HEIGHT=2.
- Nominal frame:
  - Stimulus: start, vsync fall, 2 rows of 8 bytes 0x11,0x22,…
  - Required writes: 10000, 10001, 01122, 03344, 05566, 07788, 10001, …; frame_done once; no errors.
- Queue full:
  - Stimulus: queue_full held during the second pixel of row 0.
  - Required: that pixel is absent from the write sequence, overflow=1, all other entries intact, frame_done still pulses.
- Odd-byte row:
  - Stimulus: row 0 carries 7 bytes.
  - Required: 3 pixels written, geometry_error=1, row 1 is still captured.
- Short frame:
  - Stimulus: vsync rises after 1 row.
  - Required: frame_done pulses, geometry_error=1, state returns to IDLE.
- Arming:
  - Stimulus: href pulses before start, and start during capture.
  - Required: no writes before arming; the second start is ignored.
- Reset mid-row:
  - Stimulus: reset asserted after the high byte is latched.
  - Required: no write, all outputs 0; the next frame after start is clean.
